alu_exec_sequencer: RTL and testbench

- Multi-cycle execute controller wrapped around the existing instruction decoder and ALU.
- Accepts one 32-bit instruction at a time over a valid/ready handshake.
- Drives the latched instruction to the decoder and reads operands from the register file.
- Issues the decoded ALUOp to the ALU, waits on multi-cycle ops, then writes the result back and counts retired instructions.

---
 rtl/alu_exec_sequencer_pkg.sv | 25 ++
 rtl/alu_exec_sequencer_if.sv | 13 +
 rtl/alu_exec_sequencer_timeout.sv | 26 ++
 rtl/alu_exec_sequencer.sv | 121 ++++++++++++
 tb/tb_alu_exec_sequencer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_exec_sequencer_pkg.sv
// Shared types and constants for the ALU execute sequencer.
//   state_t           : sequencer FSM states
//   TYPE_R / TYPE_I   : instruction type codes in inst[1:0]
//   MC_OP_LO..HI      : inclusive ALUOp range that needs the multi-cycle path
//   *_LSB             : bit positions of the instruction fields
//   is_mc_op()        : classifies an ALUOp as multi-cycle
package alu_seq_pkg;
  typedef enum logic [2:0] {IDLE, DECODE, READ, EXEC, WAIT, WB} state_t;

  localparam logic [1:0] TYPE_R = 2'b00;
  localparam logic [1:0] TYPE_I = 2'b01;

  localparam logic [4:0] MC_OP_LO = 5'b01011;
  localparam logic [4:0] MC_OP_HI = 5'b10001;

  localparam int TYPE_LSB = 0;   // [1:0]
  localparam int RD_LSB   = 7;   // [11:7]
  localparam int RS1_LSB  = 15;  // [19:15]
  localparam int RS2_LSB  = 20;  // [24:20]
  localparam int IMM_LSB  = 20;  // [31:20]

  function automatic logic is_mc_op(input logic [4:0] op);
    return (op >= MC_OP_LO) && (op <= MC_OP_HI);
  endfunction
endpackage

// File: rtl/alu_exec_sequencer_if.sv
// Instruction handshake between an instruction source and the sequencer.
//   inst_valid : source offers inst
//   inst_ready : sequencer can accept
//   inst       : 32-bit instruction word
// master = instruction source, slave = sequencer.
interface alu_exec_sequencer_if;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;

  modport master (output inst_valid, output inst, input inst_ready);
  modport slave  (input inst_valid, input inst, output inst_ready);
endinterface

// File: rtl/alu_exec_sequencer_timeout.sv
// Loadable down-counter that bounds the WAIT state.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (takes priority over en)
//   en        : count down by one while non-zero
//   load_val  : reload value
//   expired   : counter is zero
module alu_seq_timeout #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (en && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/alu_exec_sequencer.sv
// Multi-cycle execute controller around an external decoder and ALU.
// Accepts one instruction at a time, reads operands, runs the ALU
// (waiting on multi-cycle ops with a timeout), writes back and counts
// retired instructions.
//   clk, rst          : clock, synchronous active-high reset
//   ibus              : instruction valid/ready handshake (slave side)
//   dec_inst/dec_alu_op : latched instruction out, decoded ALUOp in
//   rf_raddr1/2, rf_rdata1/2 : register read port, data one cycle after address
//   alu_a/b/op/start, alu_done/result : ALU operands, op, start pulse, completion
//   rf_we/waddr/wdata : write-back port
//   busy, err, instret: status, error pulse, retired-instruction counter
module alu_exec_sequencer
  import alu_seq_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MC_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  alu_exec_sequencer_if.slave ibus,
  output logic [31:0]     dec_inst,
  input  logic [4:0]      dec_alu_op,
  output logic [4:0]      rf_raddr1,
  output logic [4:0]      rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [4:0]      alu_op,
  output logic            alu_start,
  input  logic            alu_done,
  input  logic [XLEN-1:0] alu_result,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            busy,
  output logic            err,
  output logic [31:0]     instret
);
  // WAIT cycles are counted T-1 .. 0, so expiry lands on the T-th WAIT cycle
  localparam logic [7:0] TMO_LOAD = 8'(MC_TIMEOUT - 1);

  state_t          state, nxt;
  logic [1:0]      itype;
  logic            is_i, illegal, mc, expired;
  logic [XLEN-1:0] imm_ext;

  assign itype   = dec_inst[TYPE_LSB +: 2];
  assign is_i    = (itype == TYPE_I);
  assign illegal = (itype != TYPE_R) && !is_i;
  assign mc      = is_mc_op(alu_op);
  assign imm_ext = {{(XLEN-12){dec_inst[IMM_LSB+11]}}, dec_inst[IMM_LSB +: 12]};

  // Read addresses follow the latched instruction; they are meaningful in DECODE
  assign rf_raddr1 = is_i ? dec_inst[RS1_LSB +: 5] : dec_inst[RS2_LSB +: 5];
  assign rf_raddr2 = dec_inst[RS1_LSB +: 5];
  assign rf_waddr  = dec_inst[RD_LSB +: 5];

  assign ibus.inst_ready = (state == IDLE) && !rst;
  assign busy            = (state != IDLE);

  alu_seq_timeout #(.W(8)) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .load     (state == EXEC),
    .en       (state == WAIT),
    .load_val (TMO_LOAD),
    .expired  (expired)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (ibus.inst_valid) nxt = DECODE;
      DECODE:  nxt = illegal ? IDLE : READ;
      READ:    nxt = EXEC;
      EXEC:    nxt = mc ? WAIT : WB;
      WAIT:    if (alu_done) nxt = WB;
               else if (expired) nxt = IDLE;
      WB:      nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Pulse outputs are gated by rst so an abort never leaks a write or error
  always_comb begin
    alu_start = 1'b0;
    err       = 1'b0;
    rf_we     = 1'b0;
    if (!rst) begin
      alu_start = (state == EXEC) && mc;
      // done wins over a same-cycle timeout
      err       = ((state == DECODE) && illegal) ||
                  ((state == WAIT) && !alu_done && expired);
      rf_we     = (state == WB) && (rf_waddr != 5'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dec_inst <= '0;
      alu_op   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      rf_wdata <= '0;
      instret  <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && ibus.inst_valid) dec_inst <= ibus.inst;
      if (state == DECODE && !illegal)      alu_op   <= dec_alu_op;
      if (state == READ) begin
        alu_a <= rf_rdata1;
        alu_b <= is_i ? imm_ext : rf_rdata2;
      end
      if ((state == EXEC && !mc) || (state == WAIT && alu_done))
        rf_wdata <= alu_result;
      if (state == WB) instret <= instret + 32'd1;
    end
  end
endmodule

// File: tb/tb_alu_exec_sequencer.sv
module tb_alu_exec_sequencer;
  localparam int TMO = 8;
  localparam int N   = 512;

  logic        clk, rst;
  logic [31:0] dec_inst, rf_rdata1, rf_rdata2, alu_a, alu_b, alu_result, rf_wdata, instret;
  logic [4:0]  dec_alu_op, rf_raddr1, rf_raddr2, alu_op, rf_waddr;
  logic        alu_start, alu_done, rf_we, busy, err;

  alu_exec_sequencer_if ibus ();

  alu_exec_sequencer #(.XLEN(32), .MC_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ibus(ibus),
    .dec_inst(dec_inst), .dec_alu_op(dec_alu_op),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .err(err), .instret(instret)
  );

  // environment: decoder returns opcode bits [6:2]; register file reads with 1-cycle latency;
  // single-cycle ALU does add for op 0, xor otherwise; multi-cycle result appears on done_cyc
  int          cyc = 0;
  int          done_cyc = -1;
  logic [31:0] mc_val = '0;
  logic [31:0] regs [32];

  initial begin clk = 0; forever #5 clk = ~clk; end
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    rf_rdata1 <= regs[rf_raddr1];
    rf_rdata2 <= regs[rf_raddr2];
  end
  assign dec_alu_op = dec_inst[6:2];
  assign alu_done   = (cyc == done_cyc);
  assign alu_result = (cyc == done_cyc) ? mc_val : ((alu_op == 5'd0) ? alu_a + alu_b : alu_a ^ alu_b);

  // expected per-cycle timeline
  logic        e_ready [N], e_busy [N], e_busy_dc [N], e_err [N], e_start [N], e_we [N], e_ab [N];
  logic [4:0]  e_waddr [N], e_op [N];
  logic [31:0] e_wdata [N], e_instret [N], e_a [N], e_b [N];
  int          vectors = 0, miscompares = 0;
  bit          chk_on = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && cyc < N) begin
      chk("inst_ready", 32'(ibus.inst_ready), 32'(e_ready[cyc]));
      if (!e_busy_dc[cyc]) chk("busy", 32'(busy), 32'(e_busy[cyc]));
      chk("err", 32'(err), 32'(e_err[cyc]));
      chk("alu_start", 32'(alu_start), 32'(e_start[cyc]));
      chk("rf_we", 32'(rf_we), 32'(e_we[cyc]));
      chk("instret", instret, e_instret[cyc]);
      if (e_we[cyc]) begin
        chk("rf_waddr", 32'(rf_waddr), 32'(e_waddr[cyc]));
        chk("rf_wdata", rf_wdata, e_wdata[cyc]);
      end
      if (e_ab[cyc]) begin
        chk("alu_a", alu_a, e_a[cyc]);
        chk("alu_b", alu_b, e_b[cyc]);
        chk("alu_op", 32'(alu_op), 32'(e_op[cyc]));
      end
    end
  end

  // Offer one instruction and record what the outputs must do, from the accept cycle c:
  // illegal -> err at c+1; single -> WB at c+4; multi -> start at c+3, WB one cycle after
  // done (done d cycles after start, 1<=d<=TMO), else err on the TMO-th WAIT cycle.
  // d=0 means done never comes; rst_rel>0 pulses rst on cycle c+rst_rel.
  task automatic issue(input logic [31:0] ins, input int d, input logic [31:0] mv,
                       input int rst_rel, output int c);
    int endc, wb, rc;
    logic [31:0] a, b, r;
    logic [4:0] op;
    bit ill, mc;
    @(posedge clk); #1;
    c = cyc;
    ibus.inst_valid = 1'b1; ibus.inst = ins;
    ill = ins[1];
    op  = ins[6:2];
    mc  = (op >= 5'd11) && (op <= 5'd17);
    a   = ins[0] ? regs[ins[19:15]] : regs[ins[24:20]];
    b   = ins[0] ? {{20{ins[31]}}, ins[31:20]} : regs[ins[19:15]];
    r   = mc ? mv : ((op == 5'd0) ? a + b : a ^ b);
    wb  = -1;
    rc  = -1;
    if (ill) begin
      endc = c + 1;
      e_err[c+1] = 1'b1;
    end else begin
      e_ab[c+3] = 1'b1; e_a[c+3] = a; e_b[c+3] = b; e_op[c+3] = op;
      if (!mc) wb = c + 4;
      else begin
        e_start[c+3] = 1'b1;
        if (d > 0) begin done_cyc = c + 3 + d; mc_val = mv; end
        if (d >= 1 && d <= TMO) wb = c + 4 + d;
        else e_err[c+3+TMO] = 1'b1;
      end
      endc = (wb >= 0) ? wb : c + 3 + TMO;
    end
    if (rst_rel > 0) begin
      rc = c + rst_rel;
      endc = rc;
      wb = -1;
      for (int k = rc; k < rc + TMO + 4; k++) begin e_err[k] = 1'b0; e_start[k] = 1'b0; end
      for (int k = rc + 1; k < N; k++) e_instret[k] = '0;
    end
    for (int k = c + 1; k <= endc; k++) begin e_busy[k] = 1'b1; e_ready[k] = 1'b0; end
    if (rc >= 0) e_busy_dc[rc] = 1'b1;
    if (wb >= 0) begin
      e_we[wb] = (ins[11:7] != 5'd0); e_waddr[wb] = ins[11:7]; e_wdata[wb] = r;
      for (int k = wb + 1; k < N; k++) e_instret[k] = e_instret[k] + 32'd1;
    end
    @(posedge clk); #1;
    ibus.inst_valid = 1'b0;
    if (rc >= 0) begin
      while (cyc < rc) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst dec_inst", dec_inst, 32'h0);
      chk("rst alu_a", alu_a, 32'h0);
      chk("rst alu_b", alu_b, 32'h0);
      chk("rst alu_op", 32'(alu_op), 32'h0);
      chk("rst rf_wdata", rf_wdata, 32'h0);
      chk("rst instret", instret, 32'h0);
    end
    while (cyc <= endc) begin @(posedge clk); #1; end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin : main
    int c;
    for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
    regs[1] = 32'd7;
    regs[2] = 32'd3;
    for (int k = 0; k < N; k++) begin
      e_ready[k] = 1'b1; e_busy[k] = 1'b0; e_busy_dc[k] = 1'b0; e_err[k] = 1'b0;
      e_start[k] = 1'b0; e_we[k] = 1'b0; e_ab[k] = 1'b0; e_waddr[k] = '0;
      e_op[k] = '0; e_wdata[k] = '0; e_instret[k] = '0; e_a[k] = '0; e_b[k] = '0;
    end
    rst = 1'b1; ibus.inst_valid = 1'b0; ibus.inst = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset inst_ready", 32'(ibus.inst_ready), 32'h1);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset instret", instret, 32'h0);
    chk("reset dec_inst", dec_inst, 32'h0);
    chk("reset rf_we", 32'(rf_we), 32'h0);
    chk("reset alu_a", alu_a, 32'h0);
    chk_on = 1'b1;

    // R-type rd=5, 7+3
    issue(32'h0011_0280, 0, 32'h0, 0, c);
    chk("lit R model wdata", e_wdata[c+4], 32'd10);
    chk("R rf_wdata", rf_wdata, 32'd10);
    chk("R instret", instret, 32'd1);
    // I-type imm=0xFFF, rs1=1, rd=2: 7 + 0xFFFFFFFF
    issue(32'hFFF0_8101, 0, 32'h0, 0, c);
    chk("lit I model alu_b", e_b[c+3], 32'hFFFF_FFFF);
    chk("I alu_b", alu_b, 32'hFFFF_FFFF);
    chk("I rf_wdata", rf_wdata, 32'd6);
    // multi-cycle op 01110, done 6 cycles after start
    issue(32'h0011_01B8, 6, 32'h1234, 0, c);
    chk("lit MC model wb cycle", 32'(e_we[c+10]), 32'h1);
    chk("MC rf_wdata", rf_wdata, 32'h1234);
    chk("MC instret", instret, 32'd3);
    // multi-cycle op 01011, done never arrives -> timeout
    issue(32'h0011_022C, 0, 32'h0, 0, c);
    chk("lit TMO model err cycle", 32'(e_err[c+3+TMO]), 32'h1);
    chk("TMO instret", instret, 32'd3);
    chk("TMO keeps wdata", rf_wdata, 32'h1234);
    // illegal types 10 and 11
    issue(32'h0000_0282, 0, 32'h0, 0, c);
    issue(32'h0000_0283, 0, 32'h0, 0, c);
    chk("ILL instret", instret, 32'd3);
    // rd=0 retires silently
    issue(32'h0011_0004, 0, 32'h0, 0, c);
    chk("RD0 instret", instret, 32'd4);
    // class boundaries: 10001 multi (done on the timeout cycle), 10010 and 01010 single
    issue(32'h0011_03C4, TMO, 32'h0000_BEEF, 0, c);
    chk("HI done-wins wdata", rf_wdata, 32'h0000_BEEF);
    issue(32'h0011_0448, 0, 32'h0, 0, c);
    chk("ABOVE single wdata", rf_wdata, 32'd4);
    issue(32'h0011_0328, 0, 32'h0, 0, c);
    chk("BELOW instret", instret, 32'd7);
    // rst in WAIT on the cycle done arrives
    issue(32'h0011_04BC, 4, 32'h0000_DEAD, 7, c);
    chk("RST inst_ready", 32'(ibus.inst_ready), 32'h1);
    // recovery
    issue(32'h0011_0280, 0, 32'h0, 0, c);
    chk("POST instret", instret, 32'd1);
    chk("POST rf_wdata", rf_wdata, 32'd10);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
